// File: rtl/elastic_buffer_pkg.sv
// elastic_buffer_pkg: width helpers and the wrapping pointer increment shared by the buffer files
package elastic_buffer_pkg;

    function automatic int cnt_w(int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(int depth);
        return depth > 2 ? $clog2(depth) : 1;
    endfunction

    // explicit compare so non-power-of-two depths wrap at DEPTH-1
    function automatic int ptr_inc(int ptr, int depth);
        return ptr == depth - 1 ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/elastic_buffer_if.sv
// elastic_buffer_if: upstream/downstream handshake, flush and occupancy bundle
interface elastic_buffer_if import elastic_buffer_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) ();
    localparam int CNT_W = cnt_w(DEPTH);
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [CNT_W-1:0]      count_o;
    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );
    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );
endinterface

// File: rtl/elastic_buffer_mem.sv
// elastic_buffer_mem: unreset register array, one write port, one asynchronous read port
module elastic_buffer_mem import elastic_buffer_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    localparam int PTR_W     = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [PTR_W-1:0]      ra,
    output logic [DATA_WIDTH-1:0] rd
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // write the addressed entry on a push
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign rd = mem[ra];
endmodule

// File: rtl/elastic_buffer.sv
// elastic_buffer: circular elastic buffer with registered ready, optional fall-through bypass and flush
module elastic_buffer import elastic_buffer_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter bit REG_OUTPUT = 1'b1
) (
    input logic             clk,
    input logic             rst,
    elastic_buffer_if.slave bus
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_next;
    logic                  ready_ff, bypass, out_valid, push, pop, wr_en, rd_en;
    logic [DATA_WIDTH-1:0] head, out_data;
    elastic_buffer_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk(clk), .we(wr_en), .wa(wr_ptr), .wd(bus.in_data_i), .ra(rd_ptr), .rd(head)
    );
    // handshakes, bypass selection and occupancy update; a bypassed beat never touches storage
    always_comb begin
        bypass     = !REG_OUTPUT && count == '0;
        out_valid  = bypass ? bus.in_valid_i : count != '0;
        out_data   = !out_valid ? '0 : bypass ? bus.in_data_i : head;
        push       = bus.in_valid_i && ready_ff;
        pop        = out_valid && bus.out_ready_i;
        wr_en      = push && !(bypass && pop);
        rd_en      = pop && !bypass;
        count_next = count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
    // pointers, count and ready; flush shares the reset path and overrides any handshake
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_ff <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
            if (rd_en) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
            count    <= count_next;
            ready_ff <= count_next < CNT_W'(DEPTH);
        end
    end
    assign bus.in_ready_o  = ready_ff;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign bus.count_o     = count;
endmodule
